intr_pc_unit: RTL and testbench

Program-counter and interrupt sequencing unit for the next-generation jacaranda core. It takes control-flow decisions from the main controller and produces the next PC, the branch flag and the register-bank select. It generalises the single-request, single-level interrupt scheme to N prioritised channels with nested interrupts. Return state is kept on a hardware return stack.

---
 rtl/jacaranda_pkg.sv | 26 ++
 rtl/intr_pc_if.sv | 37 +++
 rtl/intr_pc_unit_ret_stack.sv | 44 ++++
 rtl/intr_pc_unit.sv | 116 +++++++++++
 tb/tb_intr_pc_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/jacaranda_pkg.sv
// Shared types and helpers for the jacaranda PC/interrupt sequencing unit.
package jacaranda_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned N_IRQ  = 4;
    localparam int unsigned LVL_W  = $clog2(N_IRQ + 1);
    localparam int unsigned STK_W  = ADDR_W + 1 + LVL_W;

    // Return-stack entry: resume address, resume flag, interrupted level
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              flag;
        logic [LVL_W-1:0]  lvl;
    } stk_entry_t;

    // Lowest set index wins; N_IRQ means nothing is pending
    function automatic logic [LVL_W-1:0] prio_enc(input logic [N_IRQ-1:0] req);
        logic [LVL_W-1:0] idx;
        idx = LVL_W'(N_IRQ);
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) idx = LVL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/intr_pc_if.sv
// Control-flow and interrupt bundle between the main controller and intr_pc_unit.
interface intr_pc_if #(
    parameter int unsigned STACK_DEPTH = 4
);
    import jacaranda_pkg::*;

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                      jmp_en;
    logic                      je_en;
    logic                      ret;
    logic                      flag_w_en;
    logic                      alu_flag;
    logic [ADDR_W-1:0]         target;
    logic [N_IRQ-1:0]          int_req;
    logic [N_IRQ-1:0]          int_en;
    logic [N_IRQ*ADDR_W-1:0]   int_vec;
    logic [ADDR_W-1:0]         pc;
    logic                      flag;
    logic                      bank_sel;
    logic [N_IRQ-1:0]          int_ack;
    logic [DEPTH_W-1:0]        depth;
    logic                      stack_err;

    modport master (
        output jmp_en, je_en, ret, flag_w_en, alu_flag, target,
               int_req, int_en, int_vec,
        input  pc, flag, bank_sel, int_ack, depth, stack_err
    );

    modport slave (
        input  jmp_en, je_en, ret, flag_w_en, alu_flag, target,
               int_req, int_en, int_vec,
        output pc, flag, bank_sel, int_ack, depth, stack_err
    );

endinterface

// File: rtl/intr_pc_unit_ret_stack.sv
// Synchronous LIFO holding interrupt return state; top entry readable combinationally.
module ret_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] tos_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;

    assign full_o  = (sp_q == PTR_W'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign tos_o   = mem_q[IDX_W'(sp_q - PTR_W'(1))];

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + PTR_W'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) sp_q <= '0;
        else       sp_q <= sp_d;
    end

    // Entry contents need no reset; only the pointer defines validity
    always_ff @(posedge clock) begin
        if (!reset && push_i && !full_o) mem_q[IDX_W'(sp_q)] <= din_i;
    end

endmodule

// File: rtl/intr_pc_unit.sv
// Next-PC, branch flag and prioritised nested interrupt sequencing for the jacaranda core.
module intr_pc_unit
    import jacaranda_pkg::*;
#(
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    intr_pc_if.slave  bus
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               flag_q, flag_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               bank_sel_q;

    logic [N_IRQ-1:0]   pending;
    logic [LVL_W-1:0]   win;
    logic [ADDR_W-1:0]  win_vec;
    logic [ADDR_W-1:0]  seq_pc;
    logic               seq_flag;
    logic               accept;
    logic               do_pop;
    logic [N_IRQ-1:0]   ack_c;
    logic               stack_err_c;
    stk_entry_t         tos;
    stk_entry_t         push_entry;
    logic [STK_W-1:0]   tos_bits;
    logic               stk_full;
    logic               stk_empty;

    ret_stack #(
        .WIDTH (STK_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clock   (clock),
        .reset   (reset),
        .push_i  (accept),
        .pop_i   (do_pop),
        .din_i   (push_entry),
        .tos_o   (tos_bits),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    assign tos = stk_entry_t'(tos_bits);

    // Decode of the cycle's control-flow decision and interrupt acceptance
    always_comb begin
        pending     = bus.int_req & bus.int_en;
        win         = prio_enc(pending);
        win_vec     = '0;
        ack_c       = '0;
        do_pop      = !reset && bus.ret && !stk_empty;
        stack_err_c = !reset && bus.ret && stk_empty;
        accept      = !reset && !bus.ret && !stk_full && (win < lvl_q);

        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (win == LVL_W'(i)) win_vec = bus.int_vec[i*ADDR_W +: ADDR_W];
            ack_c[i] = accept && (win == LVL_W'(i));
        end

        if (do_pop)                           seq_pc = tos.addr;
        else if (bus.jmp_en)                  seq_pc = bus.target;
        else if (bus.je_en && flag_q)         seq_pc = bus.target;
        else                                  seq_pc = pc_q + ADDR_W'(1);

        if (do_pop)                           seq_flag = tos.flag;
        else if (bus.je_en)                   seq_flag = 1'b0;
        else if (bus.flag_w_en)               seq_flag = bus.alu_flag;
        else                                  seq_flag = flag_q;

        push_entry.addr = seq_pc;
        push_entry.flag = seq_flag;
        push_entry.lvl  = lvl_q;

        // The interrupted instruction completes; its successor is what gets saved
        pc_d    = accept ? win_vec : seq_pc;
        flag_d  = seq_flag;
        lvl_d   = lvl_q;
        depth_d = depth_q;
        if (accept) begin
            lvl_d   = win;
            depth_d = depth_q + DEPTH_W'(1);
        end else if (do_pop) begin
            lvl_d   = tos.lvl;
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= '0;
            flag_q     <= 1'b0;
            lvl_q      <= LVL_W'(N_IRQ);
            depth_q    <= '0;
            bank_sel_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            flag_q     <= flag_d;
            lvl_q      <= lvl_d;
            depth_q    <= depth_d;
            bank_sel_q <= (depth_d != '0);
        end
    end

    assign bus.pc        = pc_q;
    assign bus.flag      = flag_q;
    assign bus.bank_sel  = bank_sel_q;
    assign bus.depth     = depth_q;
    assign bus.int_ack   = ack_c;
    assign bus.stack_err = stack_err_c;

endmodule

// File: tb/tb_intr_pc_unit.sv
// Bench for intr_pc_unit: directed vector table, a stack-full sequence and a randomized model comparison.
module tb_intr_pc_unit;
    import jacaranda_pkg::*;

    logic clk;
    logic rst;

    intr_pc_if #(.STACK_DEPTH(4)) ifa ();
    intr_pc_if #(.STACK_DEPTH(2)) ifb ();

    intr_pc_unit #(.STACK_DEPTH(4)) dut_a (.clock(clk), .reset(rst), .bus(ifa.slave));
    intr_pc_unit #(.STACK_DEPTH(2)) dut_b (.clock(clk), .reset(rst), .bus(ifb.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rst;
        logic       jmp;
        logic       je;
        logic       ret;
        logic       fwe;
        logic       alu;
        logic [7:0] tgt;
        logic [3:0] req;
        logic [3:0] en;
    } in_t;

    typedef struct {
        in_t        in;
        logic [3:0] ack;
        logic       err;
        logic [7:0] pc;
        logic       flag;
        int         dep;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [N_IRQ*ADDR_W-1:0] vec_bus;
    logic [7:0]              vec_m [4];
    vec_t                    tbl [$];

    // Reference model state: index 0 = depth-4 unit, index 1 = depth-2 unit
    int         m_pc [2], m_flag [2], m_lvl [2], m_dep [2];
    int         s_pc [2][8], s_fl [2][8], s_lv [2][8];
    int         cap  [2];
    logic [3:0] e_ack [2];
    logic       e_err [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic in_t mki(input logic r, input logic j, input logic e, input logic rt,
                                input logic fw, input logic al, input logic [7:0] t,
                                input logic [3:0] rq, input logic [3:0] en);
        in_t x;
        x.rst = r; x.jmp = j; x.je = e; x.ret = rt; x.fwe = fw; x.alu = al;
        x.tgt = t; x.req = rq; x.en = en;
        return x;
    endfunction

    function automatic vec_t mk(input in_t x, input logic [3:0] ack, input logic err,
                                input logic [7:0] pc, input logic flag, input int dep);
        vec_t v;
        v.in = x; v.ack = ack; v.err = err; v.pc = pc; v.flag = flag; v.dep = dep;
        return v;
    endfunction

    task automatic apply(input in_t x);
        rst           = x.rst;
        ifa.jmp_en    = x.jmp;  ifb.jmp_en    = x.jmp;
        ifa.je_en     = x.je;   ifb.je_en     = x.je;
        ifa.ret       = x.ret;  ifb.ret       = x.ret;
        ifa.flag_w_en = x.fwe;  ifb.flag_w_en = x.fwe;
        ifa.alu_flag  = x.alu;  ifb.alu_flag  = x.alu;
        ifa.target    = x.tgt;  ifb.target    = x.tgt;
        ifa.int_req   = x.req;  ifb.int_req   = x.req;
        ifa.int_en    = x.en;   ifb.int_en    = x.en;
        ifa.int_vec   = vec_bus; ifb.int_vec  = vec_bus;
    endtask

    // Spec-level behaviour: priority pick, explicit return stack, next-PC rules
    function automatic void model_eval(input int id, input in_t x);
        int   k, spc, sfl, top;
        logic pop, acc;
        e_ack[id] = '0;
        e_err[id] = 1'b0;
        if (x.rst) begin
            m_pc[id] = 0; m_flag[id] = 0; m_lvl[id] = 4; m_dep[id] = 0;
            return;
        end
        k = 4;
        for (int i = 3; i >= 0; i--) if (x.req[i] && x.en[i]) k = i;
        pop       = x.ret && (m_dep[id] > 0);
        e_err[id] = x.ret && (m_dep[id] == 0);
        top       = m_dep[id] - 1;
        if (pop) begin
            spc = s_pc[id][top];
            sfl = s_fl[id][top];
        end else begin
            spc = (x.jmp || (x.je && m_flag[id] != 0)) ? int'(x.tgt) : (m_pc[id] + 1) % 256;
            sfl = x.je ? 0 : (x.fwe ? int'(x.alu) : m_flag[id]);
        end
        acc = !x.ret && (k < m_lvl[id]) && (m_dep[id] < cap[id]);
        if (pop) begin
            m_lvl[id] = s_lv[id][top];
            m_dep[id] = m_dep[id] - 1;
        end else if (acc) begin
            s_pc[id][m_dep[id]] = spc;
            s_fl[id][m_dep[id]] = sfl;
            s_lv[id][m_dep[id]] = m_lvl[id];
            m_dep[id]     = m_dep[id] + 1;
            m_lvl[id]     = k;
            e_ack[id][k]  = 1'b1;
            spc           = int'(vec_m[k]);
        end
        m_pc[id]   = spc;
        m_flag[id] = sfl;
    endfunction

    task automatic run_b(input in_t x, input logic [3:0] ack, input logic [7:0] pc, input int dep);
        apply(x);
        @(negedge clk);
        chk("b_ack", 32'(ifb.int_ack), 32'(ack));
        chk("b_err", 32'(ifb.stack_err), 32'(0));
        @(posedge clk); #1;
        chk("b_pc", 32'(ifb.pc), 32'(pc));
        chk("b_depth", 32'(ifb.depth), 32'(dep));
    endtask

    initial begin
        in_t x;
        vec_m[0] = 8'h20; vec_m[1] = 8'h50; vec_m[2] = 8'h40; vec_m[3] = 8'h60;
        for (int i = 0; i < 4; i++) vec_bus[i*8 +: 8] = vec_m[i];
        cap[0] = 4; cap[1] = 2;

        // rst jmp je ret fwe alu tgt req en | ack err pc flag depth
        tbl.push_back(mk(mki(1,0,0,0,0,0,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h00,0,0));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h01,0,0));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h02,0,0));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h03,0,0));
        tbl.push_back(mk(mki(0,1,0,0,0,0,8'h10,4'b0000,4'b0000), 4'b0000,0,8'h10,0,0));
        tbl.push_back(mk(mki(0,1,0,0,0,0,8'h30,4'b0100,4'b0100), 4'b0100,0,8'h40,0,1));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b0100,4'b0100), 4'b0000,0,8'h41,0,1));
        tbl.push_back(mk(mki(0,0,0,0,1,1,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h42,1,1));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b1001,4'b1111), 4'b0001,0,8'h20,1,2));
        tbl.push_back(mk(mki(0,0,1,0,0,0,8'h77,4'b1000,4'b1111), 4'b0000,0,8'h77,0,2));
        tbl.push_back(mk(mki(0,0,0,1,0,0,8'h00,4'b1000,4'b1111), 4'b0000,0,8'h43,1,1));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b1000,4'b1111), 4'b0000,0,8'h44,1,1));
        tbl.push_back(mk(mki(0,0,0,1,0,0,8'h00,4'b1000,4'b1111), 4'b0000,0,8'h30,0,0));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b1000,4'b1111), 4'b1000,0,8'h60,0,1));
        tbl.push_back(mk(mki(0,0,0,1,0,0,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h31,0,0));
        tbl.push_back(mk(mki(0,0,0,0,1,1,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h32,1,0));
        tbl.push_back(mk(mki(0,0,0,1,0,0,8'h00,4'b0000,4'b0000), 4'b0000,1,8'h33,1,0));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h34,1,0));
        tbl.push_back(mk(mki(0,1,0,0,0,0,8'hFE,4'b0000,4'b0000), 4'b0000,0,8'hFE,1,0));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b0000,4'b0000), 4'b0000,0,8'hFF,1,0));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h00,1,0));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b0100,4'b1111), 4'b0100,0,8'h40,1,1));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b0001,4'b1111), 4'b0001,0,8'h20,1,2));
        tbl.push_back(mk(mki(1,0,0,0,0,0,8'h00,4'b0010,4'b1111), 4'b0000,0,8'h00,0,0));
        tbl.push_back(mk(mki(0,0,0,0,0,0,8'h00,4'b0010,4'b1111), 4'b0010,0,8'h50,0,1));
        tbl.push_back(mk(mki(0,0,0,1,0,0,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h01,0,0));
        tbl.push_back(mk(mki(0,0,1,0,0,0,8'h99,4'b0100,4'b0100), 4'b0100,0,8'h40,0,1));
        tbl.push_back(mk(mki(0,0,0,1,0,0,8'h00,4'b0000,4'b0000), 4'b0000,0,8'h02,0,0));

        foreach (tbl[i]) begin
            apply(tbl[i].in);
            @(negedge clk);
            chk($sformatf("row%0d_ack", i), 32'(ifa.int_ack), 32'(tbl[i].ack));
            chk($sformatf("row%0d_err", i), 32'(ifa.stack_err), 32'(tbl[i].err));
            @(posedge clk); #1;
            chk($sformatf("row%0d_pc", i), 32'(ifa.pc), 32'(tbl[i].pc));
            chk($sformatf("row%0d_flag", i), 32'(ifa.flag), 32'(tbl[i].flag));
            chk($sformatf("row%0d_depth", i), 32'(ifa.depth), 32'(tbl[i].dep));
            chk($sformatf("row%0d_bank", i), 32'(ifa.bank_sel), 32'(tbl[i].dep != 0));
        end

        // Two-deep stack: full suppresses a higher-priority request until after the ret
        run_b(mki(1,0,0,0,0,0,8'h00,4'b0000,4'b0000), 4'b0000, 8'h00, 0);
        run_b(mki(0,0,0,0,0,0,8'h00,4'b1000,4'b1111), 4'b1000, 8'h60, 1);
        run_b(mki(0,0,0,0,0,0,8'h00,4'b0100,4'b1111), 4'b0100, 8'h40, 2);
        run_b(mki(0,0,0,0,0,0,8'h00,4'b0001,4'b1111), 4'b0000, 8'h41, 2);
        run_b(mki(0,0,0,0,0,0,8'h00,4'b0001,4'b1111), 4'b0000, 8'h42, 2);
        run_b(mki(0,0,0,1,0,0,8'h00,4'b0001,4'b1111), 4'b0000, 8'h61, 1);
        run_b(mki(0,0,0,0,0,0,8'h00,4'b0001,4'b1111), 4'b0001, 8'h20, 2);

        for (int i = 0; i < 4; i++) begin
            vec_m[i] = 8'($urandom_range(0, 255));
            vec_bus[i*8 +: 8] = vec_m[i];
        end

        for (int cyc = 0; cyc < 800; cyc++) begin
            x.rst = (cyc == 0) || ($urandom_range(0, 63) == 0);
            x.jmp = ($urandom_range(0, 7) == 0);
            x.je  = ($urandom_range(0, 3) == 0);
            x.ret = ($urandom_range(0, 3) == 0);
            x.fwe = ($urandom_range(0, 2) == 0);
            x.alu = 1'($urandom);
            x.tgt = 8'($urandom);
            x.req = 4'($urandom) & 4'($urandom);
            x.en  = 4'($urandom) | 4'($urandom);
            apply(x);
            @(negedge clk);
            model_eval(0, x);
            model_eval(1, x);
            chk("rnd_a_ack", 32'(ifa.int_ack), 32'(e_ack[0]));
            chk("rnd_a_err", 32'(ifa.stack_err), 32'(e_err[0]));
            chk("rnd_b_ack", 32'(ifb.int_ack), 32'(e_ack[1]));
            chk("rnd_b_err", 32'(ifb.stack_err), 32'(e_err[1]));
            @(posedge clk); #1;
            chk("rnd_a_pc", 32'(ifa.pc), 32'(m_pc[0]));
            chk("rnd_a_flag", 32'(ifa.flag), 32'(m_flag[0]));
            chk("rnd_a_depth", 32'(ifa.depth), 32'(m_dep[0]));
            chk("rnd_a_bank", 32'(ifa.bank_sel), 32'(m_dep[0] != 0));
            chk("rnd_b_pc", 32'(ifb.pc), 32'(m_pc[1]));
            chk("rnd_b_flag", 32'(ifb.flag), 32'(m_flag[1]));
            chk("rnd_b_depth", 32'(ifb.depth), 32'(m_dep[1]));
            chk("rnd_b_bank", 32'(ifb.bank_sel), 32'(m_dep[1] != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
